mul_share_arbiter: RTL

//   Shares one combinational 16x16 signed multiplier (Booth/Wallace Mul

---
 rtl/mul_share_arbiter_if.sv | 37 +++
 rtl/mul_share_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter_if
//   Bundles the requester-side and response-side handshakes of the shared
//   multiplier arbiter.
//   master : the requesters / response consumer (drive operands, rsp_ready)
//   slave  : the arbiter (drives req_ready and the tagged response)
//   Signals:
//     req_valid [NREQ]     per-requester operation request
//     req_ready [NREQ]     per-requester accept, one-hot or zero
//     req_a/req_b          NREQ packed 16-bit signed operands, slice i = [16*i+15:16*i]
//     rsp_valid/rsp_ready  response handshake
//     rsp_id               owner of rsp_data
//     rsp_data             32-bit signed product
// ---------------------------------------------------------------------------
interface mul_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) ();
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
//   Time-shares one external combinational 16x16 signed multiplier between
//   NREQ requesters using round-robin arbitration. Each accepted operation
//   produces one tagged 32-bit product on a single shared response channel.
//   Sequence per operation: IDLE (grant) -> CALC (sample product) -> RESP
//   (hold until consumed), i.e. at most one operation every three cycles.
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     bus      slave side of mul_share_arbiter_if (requests + response)
//     mul_a    registered operand a to the multiplier
//     mul_b    registered operand b to the multiplier
//     mul_res  product from the multiplier, combinational from mul_a/mul_b
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_share_arbiter_if.slave   bus,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [31:0]          mul_res
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [15:0]     mul_a_q, mul_a_d;
    logic [15:0]     mul_b_q, mul_b_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_data_q, rsp_data_d;

    logic [IDW-1:0]  winner_s;
    logic            any_valid_s;
    logic [NREQ-1:0] ready_s;
    logic [15:0]     a_sel_s;
    logic [15:0]     b_sel_s;

    // Round-robin search: first valid index strictly after ptr, wrapping.
    // Only meaningful when at least one valid bit is set.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = {IDW{1'b0}};
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && valid[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // Next-state, grant and datapath-load logic.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        ready_s     = {NREQ{1'b0}};

        any_valid_s = |bus.req_valid;
        winner_s    = rr_pick(bus.req_valid, rr_ptr_q);
        a_sel_s     = bus.req_a[int'(winner_s)*16 +: 16];
        b_sel_s     = bus.req_b[int'(winner_s)*16 +: 16];

        case (state_q)
            ST_IDLE: begin
                // Grant is shown combinationally; with valid already high the
                // handshake completes at this edge. Nothing is granted while
                // reset is asserted.
                if (any_valid_s && rst_n) begin
                    ready_s  = NREQ'(1'b1) << winner_s;
                    mul_a_d  = a_sel_s;
                    mul_b_d  = b_sel_s;
                    rsp_id_d = winner_s;
                    rr_ptr_d = winner_s;
                    state_d  = ST_CALC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                rsp_data_d  = mul_res;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            mul_a_q     <= 16'h0000;
            mul_b_q     <= 16'h0000;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= {IDW{1'b0}};
            rsp_data_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;

endmodule
